// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch control
//               block: FSM state encoding, PC increment and the NOP pattern
//               presented on the instruction bus when nothing is valid.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch controller states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding at i_pc
    S_HOLD  = 2'd1,  // instruction captured, waiting for IF/ID to accept it
    S_DROP  = 2'd2   // redirected while a request was in flight; swallow its ack
  } state_e;

  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch controller. Drives the external pc register
//               (o_pc_en/o_pc_next), issues instruction-memory requests, holds
//               a fetched instruction under IF/ID back-pressure and discards
//               in-flight data after a branch/jump redirect.
// Ports       : i_clk, i_rst          - clock, synchronous active-high reset
//               i_pc                  - current PC from the pc register
//               o_pc_next, o_pc_en    - pc register next value / load enable
//               i_stall               - IF/ID back-pressure
//               i_redirect(_pc)       - redirect request and target
//               o_imem_req/_addr      - instruction-memory request
//               i_imem_ack/_rdata     - single-cycle ack and read data
//               o_instr/_pc/_vld      - instruction delivered to IF/ID
//               o_fetch_cnt           - count of accepted instructions
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  output logic [31:0] o_pc_next,
  output logic        o_pc_en,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_vld,
  output logic [31:0] o_fetch_cnt
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  // Redirect targets are forced onto a word boundary.
  logic [31:0] redirect_tgt;
  assign redirect_tgt = i_redirect_pc & ~32'd3;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    o_pc_en      = 1'b0;
    o_pc_next    = i_pc;
    o_imem_req   = 1'b0;
    o_imem_addr  = addr_q;
    o_instr      = NOP_INSTR;
    o_instr_pc   = i_pc;
    o_instr_vld  = 1'b0;

    if (i_rst) begin
      state_d      = S_FETCH;
      addr_d       = '0;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      o_pc_en      = 1'b1;
      o_pc_next    = RESET_PC;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          o_imem_req  = 1'b1;
          o_imem_addr = i_pc;
          // Remember the address in flight so S_DROP can keep presenting it
          // unchanged after the pc register has moved to the redirect target.
          addr_d      = i_pc;
          if (i_redirect) begin
            o_pc_en   = 1'b1;
            o_pc_next = redirect_tgt;
            // With the ack in this cycle nothing remains outstanding.
            state_d   = i_imem_ack ? S_FETCH : S_DROP;
          end else if (i_imem_ack) begin
            o_instr_vld = 1'b1;
            o_instr     = i_imem_rdata;
            o_instr_pc  = i_pc;
            if (i_stall) begin
              hold_instr_d = i_imem_rdata;
              hold_pc_d    = i_pc;
              state_d      = S_HOLD;
            end else begin
              o_pc_en   = 1'b1;
              o_pc_next = i_pc + PC_INC;
            end
          end
        end

        S_HOLD: begin
          if (i_redirect) begin
            o_pc_en      = 1'b1;
            o_pc_next    = redirect_tgt;
            hold_instr_d = '0;
            hold_pc_d    = '0;
            state_d      = S_FETCH;
          end else begin
            o_instr_vld = 1'b1;
            o_instr     = hold_instr_q;
            o_instr_pc  = hold_pc_q;
            if (!i_stall) begin
              o_pc_en   = 1'b1;
              o_pc_next = i_pc + PC_INC;
              state_d   = S_FETCH;
            end
          end
        end

        S_DROP: begin
          o_imem_req  = 1'b1;
          o_imem_addr = addr_q;
          if (i_redirect) begin
            o_pc_en   = 1'b1;
            o_pc_next = redirect_tgt;
          end else if (i_imem_ack) begin
            state_d = S_FETCH;
          end
        end

        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // Only instructions actually taken by IF/ID are counted; a redirect already
  // forces o_instr_vld low.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (o_instr_vld && !i_stall) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_FETCH;
      addr_q       <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed self-checking bench for fetch_ctrl. Models the
//               external pc register and drives the instruction-memory ack
//               by hand from each directed vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc = 32'hDEAD_BEE0;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_vld;
  logic [31:0] fetch_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // External pc register.
  always @(posedge clk) begin
    if (pc_en) pc <= pc_next;
  end

  fetch_ctrl #(.RESET_PC(C_RESET_PC)) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pc         (pc),
    .o_pc_next    (pc_next),
    .o_pc_en      (pc_en),
    .i_stall      (stall),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .o_instr      (instr),
    .o_instr_pc   (instr_pc),
    .o_instr_vld  (instr_vld),
    .o_fetch_cnt  (fetch_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    step(); step();
    #1;
    check_eq("rst_req",   {31'd0, imem_req},  32'd0);
    check_eq("rst_vld",   {31'd0, instr_vld}, 32'd0);
    check_eq("rst_pc_en", {31'd0, pc_en},     32'd1);
    check_eq("rst_pcnx",  pc_next,            C_RESET_PC);
    check_eq("rst_cnt",   fetch_cnt,          32'd0);

    // Zero-wait fetch in the first cycle after reset.
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0010_0093;
    #1;
    check_eq("f0_req",   {31'd0, imem_req},  32'd1);
    check_eq("f0_addr",  imem_addr,          32'h0);
    check_eq("f0_vld",   {31'd0, instr_vld}, 32'd1);
    check_eq("f0_instr", instr,              32'h0010_0093);
    check_eq("f0_ipc",   instr_pc,           32'h0);
    check_eq("f0_pcnx",  pc_next,            32'h4);
    step(); imem_ack = 1'b0; #1;
    check_eq("f0_cnt",   fetch_cnt,          32'd1);
    check_eq("f1_addr",  imem_addr,          32'h4);

    // Ack under stall, stall held three cycles in total.
    imem_ack = 1'b1; imem_rdata = 32'h0020_8113; stall = 1'b1;
    #1;
    check_eq("st0_vld",   {31'd0, instr_vld}, 32'd1);
    check_eq("st0_pc_en", {31'd0, pc_en},     32'd0);
    step(); imem_ack = 1'b0; #1;
    check_eq("st1_req",   {31'd0, imem_req},  32'd0);
    check_eq("st1_vld",   {31'd0, instr_vld}, 32'd1);
    check_eq("st1_instr", instr,              32'h0020_8113);
    check_eq("st1_ipc",   instr_pc,           32'h4);
    check_eq("st1_pc_en", {31'd0, pc_en},     32'd0);
    step(); imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; #1;  // stray ack ignored
    check_eq("st2_req",   {31'd0, imem_req},  32'd0);
    check_eq("st2_instr", instr,              32'h0020_8113);
    check_eq("st2_cnt",   fetch_cnt,          32'd1);
    step(); imem_ack = 1'b0; stall = 1'b0; #1;
    check_eq("st3_vld",   {31'd0, instr_vld}, 32'd1);
    check_eq("st3_instr", instr,              32'h0020_8113);
    check_eq("st3_pc_en", {31'd0, pc_en},     32'd1);
    check_eq("st3_pcnx",  pc_next,            32'h8);
    step(); #1;
    check_eq("st4_cnt",   fetch_cnt,          32'd2);
    check_eq("st4_req",   {31'd0, imem_req},  32'd1);
    check_eq("st4_addr",  imem_addr,          32'h8);

    // Redirect two cycles into a 4-cycle-latency fetch at pc=8.
    step(); #1;
    check_eq("rd1_addr",  imem_addr,          32'h8);
    step(); redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
    check_eq("rd2_pcnx",  pc_next,            32'h100);
    check_eq("rd2_pc_en", {31'd0, pc_en},     32'd1);
    check_eq("rd2_vld",   {31'd0, instr_vld}, 32'd0);
    step(); redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1111_1111; #1;
    check_eq("rd3_req",   {31'd0, imem_req},  32'd1);
    check_eq("rd3_addr",  imem_addr,          32'h8);
    check_eq("rd3_vld",   {31'd0, instr_vld}, 32'd0);
    check_eq("rd3_pc_en", {31'd0, pc_en},     32'd0);
    step(); imem_ack = 1'b0; #1;
    check_eq("rd4_addr",  imem_addr,          32'h100);
    check_eq("rd4_req",   {31'd0, imem_req},  32'd1);
    check_eq("rd4_cnt",   fetch_cnt,          32'd2);

    // Redirect and ack in the same cycle.
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222; redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    check_eq("ra_vld",    {31'd0, instr_vld}, 32'd0);
    check_eq("ra_pcnx",   pc_next,            32'h200);
    step(); imem_ack = 1'b0; redirect = 1'b0; #1;
    check_eq("ra_cnt",    fetch_cnt,          32'd2);
    check_eq("ra_addr",   imem_addr,          32'h200);

    // PC wrap at the top of the address space.
    imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect = 1'b0; imem_rdata = 32'h3333_3333; #1;
    check_eq("wr_ipc",    instr_pc,           32'hFFFF_FFFC);
    check_eq("wr_pcnx",   pc_next,            32'h0);
    step(); imem_ack = 1'b0; #1;
    check_eq("wr_cnt",    fetch_cnt,          32'd3);
    check_eq("wr_addr",   imem_addr,          32'h0);

    // Reset while in S_DROP.
    redirect = 1'b1; redirect_pc = 32'h40;
    step(); redirect = 1'b0; #1;
    check_eq("dr_req",    {31'd0, imem_req},  32'd1);
    check_eq("dr_addr",   imem_addr,          32'h0);
    rst = 1'b1; #1;
    check_eq("drr_req",   {31'd0, imem_req},  32'd0);
    check_eq("drr_pcnx",  pc_next,            C_RESET_PC);
    step(); #1;
    check_eq("drr1_req",  {31'd0, imem_req},  32'd0);
    check_eq("drr1_vld",  {31'd0, instr_vld}, 32'd0);
    check_eq("drr1_pcnx", pc_next,            C_RESET_PC);
    check_eq("drr1_cnt",  fetch_cnt,          32'd0);
    rst = 1'b0; #1;
    check_eq("drr2_req",  {31'd0, imem_req},  32'd1);
    check_eq("drr2_addr", imem_addr,          C_RESET_PC);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_ctrl
`default_nettype wire
